// File: rtl/xvga_sync_decoder.sv
// -----------------------------------------------------------------------------
// xvga_sync_decoder
//
// Receive-side companion of the XVGA timing generator. Watches active-low
// hsync/vsync on the pixel clock, rebuilds the pixel/line counters so they
// track the source cycle-for-cycle, measures the line period and the number
// of lines per frame, and reports when the stream matches the expected
// timing.
//
// Ports
//   vclock_in        pixel clock
//   rst_in           synchronous active-high reset
//   hsync_in         active-low horizontal sync
//   vsync_in         active-low vertical sync
//   hcount_out       recovered pixel number (11b)
//   vcount_out       recovered line number (10b)
//   blank_out        1 outside the active area or while unlocked
//   locked_out       stream timing matches the parameters
//   frame_start_out  1-cycle pulse at pixel (0,0) while locked
//   h_total_out      last measured hsync period in clocks (12b)
//   v_total_out      last measured lines per frame (10b)
//   error_out        1-cycle pulse when lock is lost
// -----------------------------------------------------------------------------
module xvga_sync_decoder #(
   parameter int DISPLAY_WIDTH  = 1024,
   parameter int DISPLAY_HEIGHT = 768,
   parameter int H_FP           = 24,
   parameter int H_SYNC_PULSE   = 136,
   parameter int H_BP           = 160,
   parameter int V_FP           = 3,
   parameter int V_SYNC_PULSE   = 6,
   parameter int V_BP           = 29,
   parameter int LOCK_FRAMES    = 2
) (
   input  logic        vclock_in,
   input  logic        rst_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out,
   output logic        blank_out,
   output logic        locked_out,
   output logic        frame_start_out,
   output logic [11:0] h_total_out,
   output logic [9:0]  v_total_out,
   output logic        error_out
);

   localparam int H_TOTAL = DISPLAY_WIDTH + H_FP + H_SYNC_PULSE + H_BP;
   localparam int V_TOTAL = DISPLAY_HEIGHT + V_FP + V_SYNC_PULSE + V_BP;

   // The source's counter has already advanced one step past the sync
   // edge by the time the edge is registered here, hence the +1 loads.
   localparam logic [10:0] H_LOAD    = 11'(DISPLAY_WIDTH + H_FP + 1);
   localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACTIVE  = 11'(DISPLAY_WIDTH);
   localparam logic [9:0]  V_LOAD    = 10'(DISPLAY_HEIGHT + V_FP + 1);
   localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACTIVE  = 10'(DISPLAY_HEIGHT);
   localparam logic [11:0] H_PERIOD  = 12'(H_TOTAL);
   localparam logic [11:0] H_TIMEOUT = 12'(2 * H_TOTAL - 1);
   localparam logic [9:0]  V_LINES   = 10'(V_TOTAL);
   localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic        hs_q, vs_q;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [11:0] h_per;
   logic [9:0]  lines;
   logic [11:0] h_total;
   logic [9:0]  v_total;
   logic        frame_ok, frame_ok_nxt;
   logic [3:0]  good, good_nxt;
   logic        err, err_nxt;

   logic        hfall, vfall, hwrap, timeout, bad_h, bad_v;
   logic [11:0] per_meas;
   logic [9:0]  lines_meas;
   logic [3:0]  good_inc;

   function automatic logic [11:0] sat_inc12(input logic [11:0] v);
      return (v == 12'hFFF) ? v : v + 12'd1;
   endfunction

   assign hfall = ~hsync_in & hs_q;
   assign vfall = ~vsync_in & vs_q;

   // A re-snap on hfall takes priority over the natural end-of-line wrap,
   // so a line only advances vcount when the counter really rolls over.
   assign hwrap = ~hfall & (hcount >= H_LAST);

   assign per_meas   = sat_inc12(h_per);
   assign lines_meas = lines + {9'd0, hfall};
   assign bad_h      = hfall & (per_meas != H_PERIOD);
   assign bad_v      = vfall & (lines_meas != V_LINES);
   assign timeout    = ~hfall & (h_per == H_TIMEOUT);
   assign good_inc   = good + 4'd1;

   always_comb begin
      state_nxt    = state;
      frame_ok_nxt = frame_ok;
      good_nxt     = good;
      err_nxt      = 1'b0;
      if (timeout) begin
         state_nxt = SEARCH;
         err_nxt   = (state == LOCKED);
      end else begin
         case (state)
            SEARCH: begin
               if (vfall) begin
                  state_nxt    = TRACK;
                  good_nxt     = 4'd0;
                  frame_ok_nxt = 1'b1;
               end
            end
            TRACK: begin
               if (vfall) begin
                  // A bad period on the closing hfall still spoils the frame.
                  if (frame_ok & ~bad_h & ~bad_v) begin
                     good_nxt = good_inc;
                     if (good_inc == LOCK_N) state_nxt = LOCKED;
                  end else begin
                     good_nxt = 4'd0;
                  end
                  frame_ok_nxt = 1'b1;
               end else if (bad_h) begin
                  frame_ok_nxt = 1'b0;
               end
            end
            LOCKED: begin
               if (bad_h | bad_v) begin
                  state_nxt = SEARCH;
                  err_nxt   = 1'b1;
               end
            end
            default: state_nxt = SEARCH;
         endcase
      end
   end

   always_ff @(posedge vclock_in) begin
      if (rst_in) begin
         // History starts high so an edge needs a real high-to-low step.
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         hcount   <= 11'd0;
         vcount   <= 10'd0;
         h_per    <= 12'd0;
         lines    <= 10'd0;
         h_total  <= 12'd0;
         v_total  <= 10'd0;
         state    <= SEARCH;
         frame_ok <= 1'b0;
         good     <= 4'd0;
         err      <= 1'b0;
      end else begin
         hs_q <= hsync_in;
         vs_q <= vsync_in;

         if (hfall)                hcount <= H_LOAD;
         else if (hcount >= H_LAST) hcount <= 11'd0;
         else                      hcount <= hcount + 11'd1;

         if (vfall)                vcount <= V_LOAD;
         else if (hwrap)           vcount <= (vcount >= V_LAST) ? 10'd0 : vcount + 10'd1;

         h_per <= hfall ? 12'd0 : sat_inc12(h_per);
         if (hfall) h_total <= per_meas;

         // A coincident hfall belongs to the frame that is just starting.
         if (vfall) begin
            v_total <= lines_meas;
            lines   <= {9'd0, hfall};
         end else begin
            lines   <= lines_meas;
         end

         state    <= state_nxt;
         frame_ok <= frame_ok_nxt;
         good     <= good_nxt;
         err      <= err_nxt;
      end
   end

   assign hcount_out      = hcount;
   assign vcount_out      = vcount;
   assign h_total_out     = h_total;
   assign v_total_out     = v_total;
   assign locked_out      = (state == LOCKED);
   assign error_out       = err;
   assign blank_out       = ~locked_out | (hcount >= H_ACTIVE) | (vcount >= V_ACTIVE);
   assign frame_start_out = locked_out & (hcount == 11'd0) & (vcount == 10'd0);

endmodule

// File: tb/tb_xvga_sync_decoder.sv
module tb_xvga_sync_decoder;

   // Reduced raster so whole frames fit in a short run.
   localparam int W   = 16, HFP = 2, HS = 4, HBP = 4;
   localparam int HT  = W + HFP + HS + HBP;
   localparam int H   = 8, VFP = 1, VS = 2, VBP = 2;
   localparam int VT  = H + VFP + VS + VBP;
   localparam int LF  = 2;
   localparam int F   = HT * VT;
   localparam int VS0 = (H + VFP) * HT + HT - 1;

   logic        clk = 1'b0;
   logic        rst_in = 1'b1;
   logic        hsync_in = 1'b1;
   logic        vsync_in = 1'b1;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
   logic        blank_out, locked_out, frame_start_out, error_out;
   logic [11:0] h_total_out;
   logic [9:0]  v_total_out;

   xvga_sync_decoder #(
      .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H),
      .H_FP(HFP), .H_SYNC_PULSE(HS), .H_BP(HBP),
      .V_FP(VFP), .V_SYNC_PULSE(VS), .V_BP(VBP),
      .LOCK_FRAMES(LF)
   ) dut (
      .vclock_in(clk), .rst_in(rst_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hcount_out(hcount_out), .vcount_out(vcount_out), .blank_out(blank_out),
      .locked_out(locked_out), .frame_start_out(frame_start_out),
      .h_total_out(h_total_out), .v_total_out(v_total_out), .error_out(error_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // source raster position and disturbance controls
   int sh = 0, sv = 0;
   bit force_hs_hi = 0, force_sync_lo = 0, skip_px = 0, skip_ln = 0, chk_src = 0;

   // reference model state
   bit p_hs = 1, p_vs = 1;
   int h_anchor = 0, h_age = 0, v_anchor = 0, v_age = 0;
   int e_hc = 0, e_vc = 0, e_htot = 0, e_vtot = 0, lines = 0;
   int mode = 0, good = 0;
   int per_q[$];
   bit e_err = 0;

   int cyc = 0, first_vf_cyc = -1, lock_cyc = -1, fs_count = 0, err_seen = 0;
   bit prev_locked = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Behavioural model: positions are anchor + age since the last sync edge;
   // frame quality is judged from the list of line periods seen in the frame.
   task automatic model_edge(input bit r, input bit hs, input bit vs);
      bit hf, vf, to, wrap, ok;
      int per, lm, age_sat;
      e_err = 0;
      if (r) begin
         p_hs = 1; p_vs = 1;
         h_anchor = 0; h_age = 0; v_anchor = 0; v_age = 0;
         e_hc = 0; e_vc = 0; e_htot = 0; e_vtot = 0; lines = 0;
         mode = 0; good = 0; per_q.delete();
         return;
      end
      hf = p_hs && !hs;
      vf = p_vs && !vs;
      age_sat = (h_age > 4095) ? 4095 : h_age;
      per = (age_sat + 1 > 4095) ? 4095 : age_sat + 1;
      to = !hf && (age_sat == 2 * HT - 1);

      if (hf) begin h_anchor = W + HFP + 1; h_age = 0; end
      else h_age++;
      e_hc = (h_anchor + h_age) % HT;
      wrap = !hf && (e_hc == 0);
      if (vf) begin v_anchor = H + VFP + 1; v_age = 0; end
      else if (wrap) v_age++;
      e_vc = (v_anchor + v_age) % VT;

      lm = lines + (hf ? 1 : 0);
      if (hf) e_htot = per;
      if (vf) begin e_vtot = lm; lines = hf ? 1 : 0; end
      else lines = lm;

      if (to) begin
         if (mode == 2) e_err = 1;
         mode = 0;
         per_q.delete();
      end else if (mode == 0) begin
         if (vf) begin mode = 1; good = 0; per_q.delete(); first_vf_cyc = cyc; end
      end else if (mode == 1) begin
         if (hf) per_q.push_back(per);
         if (vf) begin
            ok = (lm == VT);
            foreach (per_q[i]) if (per_q[i] != HT) ok = 0;
            good = ok ? good + 1 : 0;
            per_q.delete();
            if (good == LF) mode = 2;
         end
      end else begin
         if ((hf && per != HT) || (vf && lm != VT)) begin mode = 0; e_err = 1; end
      end
      p_hs = hs;
      p_vs = vs;
   endtask

   task automatic tick(input bit r);
      bit hs, vs;
      int p, lk;
      hs = !(sh >= W + HFP && sh < W + HFP + HS) || force_hs_hi;
      p  = sv * HT + sh;
      vs = !(p >= VS0 && p < VS0 + VS * HT);
      if (force_sync_lo) begin hs = 0; vs = 0; end
      rst_in = r; hsync_in = hs; vsync_in = vs;
      @(posedge clk);
      model_edge(r, hs, vs);
      sh = sh + 1;
      if (skip_px && sh == 5) begin sh = 6; skip_px = 0; end
      if (sh >= HT) begin
         sh = 0;
         sv = sv + 1;
         if (skip_ln && sv == 3) begin sv = 4; skip_ln = 0; end
         if (sv >= VT) sv = 0;
      end
      #1;
      lk = (mode == 2) ? 1 : 0;
      chk("hcount", 32'(hcount_out), e_hc);
      chk("vcount", 32'(vcount_out), e_vc);
      chk("locked", 32'(locked_out), lk);
      chk("error", 32'(error_out), e_err ? 1 : 0);
      chk("blank", 32'(blank_out), (lk == 0 || e_hc >= W || e_vc >= H) ? 1 : 0);
      chk("frame_start", 32'(frame_start_out), (lk == 1 && e_hc == 0 && e_vc == 0) ? 1 : 0);
      chk("h_total", 32'(h_total_out), e_htot);
      chk("v_total", 32'(v_total_out), e_vtot);
      if (chk_src) begin
         chk("src_hcount", 32'(hcount_out), sh);
         chk("src_vcount", 32'(vcount_out), sv);
      end
      if (frame_start_out) fs_count++;
      if (error_out) err_seen++;
      if (locked_out && !prev_locked) lock_cyc = cyc;
      prev_locked = locked_out;
      cyc++;
   endtask

   task automatic run_until_locked(input int budget, input string tag);
      int n = 0;
      while (!locked_out && n < budget) begin tick(0); n++; end
      chk(tag, 32'(locked_out), 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0);
   endtask

   initial begin
      int ht_before;
      // stream begins mid-frame in the active area
      sh = $urandom_range(1, W - 1);
      sv = $urandom_range(1, H - 1);
      for (int i = 0; i < 3; i++) tick(1);
      chk("rst_hcount", 32'(hcount_out), 0);
      chk("rst_vcount", 32'(vcount_out), 0);
      chk("rst_blank", 32'(blank_out), 1);
      chk("rst_locked", 32'(locked_out), 0);
      chk("rst_h_total", 32'(h_total_out), 0);
      chk("rst_v_total", 32'(v_total_out), 0);

      for (int i = 0; i < HT + 2 && !(sh == W + HFP + 1); i++) tick(0);
      chk("snap_h", 32'(hcount_out), W + HFP + 1);
      for (int i = 0; i < F + 2 && !(sv == H + VFP + 1 && sh == 0); i++) tick(0);
      chk("snap_v", 32'(vcount_out), H + VFP + 1);

      run_until_locked(4 * F, "lock_initial");
      chk("lock_latency", 32'(lock_cyc - first_vf_cyc), 2 * F);

      // one nominal locked frame, tracked against the source position
      chk_src = 1; fs_count = 0;
      idle(F);
      chk_src = 0;
      chk("fs_per_frame", 32'(fs_count), 1);
      chk("nom_h_total", 32'(h_total_out), HT);
      chk("nom_v_total", 32'(v_total_out), VT);

      // one short line
      idle($urandom_range(0, 3 * HT));
      err_seen = 0; skip_px = 1;
      for (int i = 0; i < 3 * HT && !error_out; i++) tick(0);
      chk("short_line_err", 32'(error_out), 1);
      chk("short_line_htot", 32'(h_total_out), HT - 1);
      chk("short_line_unlock", 32'(locked_out), 0);
      run_until_locked(5 * F, "short_line_relock");
      chk("short_line_pulses", 32'(err_seen), 1);

      // one short frame
      idle($urandom_range(0, 3 * HT));
      err_seen = 0; skip_ln = 1;
      for (int i = 0; i < 3 * F && !error_out; i++) tick(0);
      chk("short_frame_err", 32'(error_out), 1);
      chk("short_frame_vtot", 32'(v_total_out), VT - 1);
      run_until_locked(5 * F, "short_frame_relock");
      chk("short_frame_pulses", 32'(err_seen), 1);

      // hsync stuck high
      for (int i = 0; i < HT + 2 && !(sh == W + HFP + HS); i++) tick(0);
      ht_before = int'(h_total_out);
      err_seen = 0; force_hs_hi = 1;
      idle(2 * HT);
      force_hs_hi = 0;
      chk("timeout_pulses", 32'(err_seen), 1);
      chk("timeout_unlock", 32'(locked_out), 0);
      chk("timeout_htot", 32'(h_total_out), ht_before);
      run_until_locked(5 * F, "timeout_relock");

      // reset pulse mid-frame with both sync lines low during it
      for (int i = 0; i < F + 2 && !(sh == 2 && sv == 2); i++) tick(0);
      force_sync_lo = 1;
      tick(1);
      force_sync_lo = 0;
      chk("mrst_hcount", 32'(hcount_out), 0);
      chk("mrst_vcount", 32'(vcount_out), 0);
      chk("mrst_blank", 32'(blank_out), 1);
      chk("mrst_locked", 32'(locked_out), 0);
      tick(0);
      chk("mrst_no_edge", 32'(hcount_out), 1);
      run_until_locked(4 * F, "mrst_relock");
      chk("mrst_lock_latency", 32'(lock_cyc - first_vf_cyc), 2 * F);

      chk_src = 1;
      idle(F);
      chk_src = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
